// File: rtl/conv_lane_sched_pkg.sv
// Shared types, default geometry and width helpers for the convolution lane sequencer.
package conv_lane_sched_pkg;

  localparam int DEF_SIZE_X  = 112;
  localparam int DEF_SIZE_F  = 49;
  localparam int DEF_LANES   = 12;
  localparam int DEF_MAC_LAT = 2;

  localparam int Y_LEN      = DEF_SIZE_X - DEF_SIZE_F + 1;
  localparam int NUM_GROUPS = (Y_LEN + DEF_LANES - 1) / DEF_LANES;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Address width for n words; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int y_len_of(input int size_x, input int size_f);
    return size_x - size_f + 1;
  endfunction

  function automatic int groups_of(input int y_len, input int lanes);
    return (y_len + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/conv_lane_sched_load_ctr.sv
// Registered-ready loader: counts accepted words, drops ready on the last accept,
// and re-arms one edge after restart while the sequencer sits in LOAD.
module conv_lane_sched_load_ctr
  import conv_lane_sched_pkg::*;
#(
  parameter int N  = DEF_SIZE_X,
  parameter int AW = addr_w(DEF_SIZE_X)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          restart,
  input  logic          valid,
  output logic          ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          loaded,
  output logic          fin
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [AW-1:0] cnt;

  assign wr_en   = valid & ready;
  assign fin     = wr_en & (cnt == LAST);
  assign wr_addr = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready  <= 1'b0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (restart) begin
      ready  <= 1'b0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (fin) begin
      // address holds at the last word; nothing is written until restart
      ready  <= 1'b0;
      loaded <= 1'b1;
    end else if (wr_en) begin
      cnt <= cnt + AW'(1);
    end else if (arm && !loaded) begin
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/conv_lane_sched.sv
// Control sequencer for the lane-parallel convolution datapath; no data passes through.
//   state | meaning
//   LOAD  | accept x and f words into memory
//   CLEAR | clear lane accumulators for group g
//   MAC   | walk k over f, x base g+k
//   FLUSH | wait MAC_LAT cycles for lane outputs to settle
//   DRAIN | hand out lanes 0..n-1 under y_ready backpressure
module conv_lane_sched
  import conv_lane_sched_pkg::*;
#(
  parameter  int SIZE_X  = DEF_SIZE_X,
  parameter  int SIZE_F  = DEF_SIZE_F,
  parameter  int LANES   = DEF_LANES,
  parameter  int MAC_LAT = DEF_MAC_LAT,
  localparam int XAW     = addr_w(SIZE_X),
  localparam int FAW     = addr_w(SIZE_F),
  localparam int SW      = addr_w(LANES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic           f_valid,
  output logic           f_ready,
  output logic           wr_en_x,
  output logic [XAW-1:0] wr_addr_x,
  output logic           wr_en_f,
  output logic [FAW-1:0] wr_addr_f,
  output logic [XAW:0]   rd_addr_x_base,
  output logic [FAW-1:0] rd_addr_f,
  output logic           clear_acc,
  output logic           en_acc,
  output logic [SW-1:0]  y_sel,
  output logic           y_valid,
  input  logic           y_ready,
  output logic           frame_done
);

  localparam int GW  = XAW + 1;
  localparam int YL  = y_len_of(SIZE_X, SIZE_F);
  localparam int FLW = addr_w(MAC_LAT + 1);

  localparam logic [FAW-1:0] K_LAST  = FAW'(SIZE_F - 1);
  localparam logic [GW-1:0]  G_Y     = GW'(YL);
  localparam logic [GW-1:0]  G_STEP  = GW'(LANES);
  localparam logic [SW-1:0]  J_FULL  = SW'(LANES - 1);
  localparam logic [FLW-1:0] FL_INIT = FLW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t         state, state_nx;
  logic [FAW-1:0] k;
  logic [GW-1:0]  g;
  logic [GW-1:0]  remaining;
  logic [SW-1:0]  j;
  logic [SW-1:0]  j_last;
  logic [FLW-1:0] flush_tmr;
  logic           arm;
  logic           x_loaded, x_fin;
  logic           f_loaded, f_fin;
  logic           y_hs, grp_end, frame_end;

  assign arm = (state == LOAD);

  conv_lane_sched_load_ctr #(.N(SIZE_X), .AW(XAW)) u_load_x (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .restart (frame_end),
    .valid   (x_valid),
    .ready   (x_ready),
    .wr_en   (wr_en_x),
    .wr_addr (wr_addr_x),
    .loaded  (x_loaded),
    .fin     (x_fin)
  );

  conv_lane_sched_load_ctr #(.N(SIZE_F), .AW(FAW)) u_load_f (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .restart (frame_end),
    .valid   (f_valid),
    .ready   (f_ready),
    .wr_en   (wr_en_f),
    .wr_addr (wr_addr_f),
    .loaded  (f_loaded),
    .fin     (f_fin)
  );

  // The last group may be partial: n = min(LANES, Y-g).
  always_comb begin
    remaining = G_Y - g;
    j_last    = (remaining >= G_STEP) ? J_FULL : SW'(remaining - GW'(1));
  end

  assign y_hs      = (state == DRAIN) & y_ready;
  assign grp_end   = y_hs & (j == j_last);
  assign frame_end = grp_end & ((g + G_STEP) >= G_Y);

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: begin
        if ((x_loaded || x_fin) && (f_loaded || f_fin)) state_nx = CLEAR;
      end
      CLEAR: state_nx = MAC;
      MAC: begin
        if (k == K_LAST) state_nx = (MAC_LAT == 0) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        if (flush_tmr == '0) state_nx = DRAIN;
      end
      DRAIN: begin
        if (grp_end) state_nx = frame_end ? LOAD : CLEAR;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      k          <= '0;
      g          <= '0;
      j          <= '0;
      flush_tmr  <= '0;
      en_acc     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      en_acc     <= (state == MAC);
      frame_done <= frame_end;
      unique case (state)
        LOAD: begin
          k <= '0;
          g <= '0;
          j <= '0;
        end
        CLEAR: k <= '0;
        MAC: begin
          if (k == K_LAST) begin
            k         <= '0;
            flush_tmr <= FL_INIT;
          end else begin
            k <= k + FAW'(1);
          end
        end
        FLUSH: begin
          if (flush_tmr != '0) flush_tmr <= flush_tmr - FLW'(1);
        end
        DRAIN: begin
          if (y_hs) begin
            if (j == j_last) begin
              j <= '0;
              g <= frame_end ? '0 : g + G_STEP;
            end else begin
              j <= j + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign clear_acc      = (state == CLEAR);
  assign y_valid        = (state == DRAIN);
  assign y_sel          = j;
  assign rd_addr_f      = k;
  assign rd_addr_x_base = g + GW'(k);

endmodule

// File: tb/tb_conv_lane_sched.sv
// Randomized bench for conv_lane_sched against a frame-timeline reference model.
module tb_conv_lane_sched;

  localparam int SX  = 112;
  localparam int SF  = 49;
  localparam int LN  = 12;
  localparam int ML  = 2;
  localparam int YL  = SX - SF + 1;
  localparam int DR  = 1 + SF + ML;   // cycle offset from clear to first y_valid
  localparam int XAW = $clog2(SX);
  localparam int FAW = $clog2(SF);
  localparam int SW  = $clog2(LN);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           x_valid = 1'b0, f_valid = 1'b0, y_ready = 1'b0;
  logic           x_ready, f_ready, wr_en_x, wr_en_f;
  logic [XAW-1:0] wr_addr_x;
  logic [FAW-1:0] wr_addr_f;
  logic [XAW:0]   rd_addr_x_base;
  logic [FAW-1:0] rd_addr_f;
  logic           clear_acc, en_acc, y_valid, frame_done;
  logic [SW-1:0]  y_sel;

  always #5 clk = ~clk;

  conv_lane_sched dut (
    .clk            (clk),
    .reset          (reset),
    .x_valid        (x_valid),
    .x_ready        (x_ready),
    .f_valid        (f_valid),
    .f_ready        (f_ready),
    .wr_en_x        (wr_en_x),
    .wr_addr_x      (wr_addr_x),
    .wr_en_f        (wr_en_f),
    .wr_addr_f      (wr_addr_f),
    .rd_addr_x_base (rd_addr_x_base),
    .rd_addr_f      (rd_addr_f),
    .clear_acc      (clear_acc),
    .en_acc         (en_acc),
    .y_sel          (y_sel),
    .y_valid        (y_valid),
    .y_ready        (y_ready),
    .frame_done     (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 = loading, 1 = computing group g (cleared at cycle t0)
  int cyc = 0, mode = 0, xcnt = 0, fcnt = 0, ready_from = 1, fd_cyc = -1;
  int t0 = 0, g = 0, hs = 0, dut_hs = 0, fd_seen = 0, frames = 0;
  int px = 100, pf = 100, py = 100, stall_left = 0;
  bit f_after_x = 1'b0, stall_armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    x_valid = ($urandom_range(99) < px);
    f_valid = (!f_after_x || xcnt >= SX) && ($urandom_range(99) < pf);
    if (stall_armed && mode == 1 && (cyc - t0) >= DR && hs == 7) begin
      stall_left  = 5;
      stall_armed = 1'b0;
    end
    if (stall_left > 0) begin
      y_ready = 1'b0;
      stall_left--;
    end else begin
      y_ready = ($urandom_range(99) < py);
    end
  endtask

  task automatic model_step();
    int  d, n;
    bit  exr, efr, in_mac, in_drain;
    if (y_valid === 1'b1 && y_ready) dut_hs++;
    if (frame_done === 1'b1) fd_seen++;
    if (mode == 0) begin
      exr = (cyc >= ready_from) && (xcnt < SX);
      efr = (cyc >= ready_from) && (fcnt < SF);
      chk("x_ready", x_ready, exr);
      chk("f_ready", f_ready, efr);
      chk("wr_en_x", wr_en_x, exr & x_valid);
      chk("wr_en_f", wr_en_f, efr & f_valid);
      if (exr && x_valid) chk("wr_addr_x", wr_addr_x, xcnt);
      if (efr && f_valid) chk("wr_addr_f", wr_addr_f, fcnt);
      chk("load_clear_acc", clear_acc, 0);
      chk("load_en_acc", en_acc, 0);
      chk("load_y_valid", y_valid, 0);
      chk("frame_done", frame_done, cyc == fd_cyc);
      if (exr && x_valid) xcnt++;
      if (efr && f_valid) fcnt++;
      if (xcnt == SX && fcnt == SF) begin
        mode = 1; t0 = cyc + 1; g = 0; hs = 0;
      end
    end else begin
      d        = cyc - t0;
      n        = (YL - g < LN) ? YL - g : LN;
      in_mac   = (d >= 1) && (d <= SF);
      in_drain = (d >= DR);
      chk("clear_acc", clear_acc, d == 0);
      chk("en_acc", en_acc, (d >= 2) && (d <= SF + 1));
      chk("y_valid", y_valid, in_drain);
      if (in_mac) begin
        chk("rd_addr_f", rd_addr_f, d - 1);
        chk("rd_addr_x_base", rd_addr_x_base, g + d - 1);
      end
      if (in_drain) chk("y_sel", y_sel, hs);
      chk("busy_x_ready", x_ready, 0);
      chk("busy_f_ready", f_ready, 0);
      chk("busy_wr_en", {wr_en_x, wr_en_f}, 0);
      chk("busy_frame_done", frame_done, 0);
      if (in_drain && y_ready) begin
        hs++;
        if (hs == n) begin
          if (g + LN < YL) begin
            g += LN; t0 = cyc + 1; hs = 0;
          end else begin
            chk("y_per_frame", dut_hs, YL);
            dut_hs = 0; mode = 0; xcnt = 0; fcnt = 0;
            fd_cyc = cyc + 1; ready_from = cyc + 2; frames++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    model_step();
  endtask

  task automatic run_frame(input int px_i, input int pf_i, input bit fax, input int py_i,
                           input bit stall);
    int start;
    px = px_i; pf = pf_i; f_after_x = fax; py = py_i; stall_armed = stall;
    start = frames;
    for (int i = 0; i < 4000 && frames == start; i++) tick();
    chk("frame_completes", frames - start, 1);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_x_ready"}, x_ready, 0);
    chk({pfx, "_f_ready"}, f_ready, 0);
    chk({pfx, "_clear_acc"}, clear_acc, 0);
    chk({pfx, "_en_acc"}, en_acc, 0);
    chk({pfx, "_y_valid"}, y_valid, 0);
    chk({pfx, "_frame_done"}, frame_done, 0);
    chk({pfx, "_rd_addr_f"}, rd_addr_f, 0);
    chk({pfx, "_rd_addr_x_base"}, rd_addr_x_base, 0);
    chk({pfx, "_y_sel"}, y_sel, 0);
    chk({pfx, "_wr_addr_x"}, wr_addr_x, 0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b0;
    x_valid = 1'b0; f_valid = 1'b0; y_ready = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mode = 0; xcnt = 0; fcnt = 0; dut_hs = 0;
    ready_from = cyc + 1; fd_cyc = -1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    ready_from = cyc + 1;

    run_frame(100, 100, 1'b0, 100, 1'b0);
    run_frame(60, 40, 1'b1, 70, 1'b0);
    run_frame(100, 100, 1'b0, 100, 1'b1);

    px = 100; pf = 100; py = 100; f_after_x = 1'b0;
    for (int i = 0; i < 400 && !(mode == 1 && cyc - t0 == 20); i++) tick();
    chk("reached_mac", (mode == 1) && (cyc - t0 == 20), 1);
    reset_mid();

    run_frame(80, 80, 1'b0, 60, 1'b0);
    repeat (3) tick();
    chk("frame_done_pulses", fd_seen, frames);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
